// File: rtl/op_arb_pkg.sv
// op_arb_pkg: shared state encoding and select codes for the operand-data arbiter.
package op_arb_pkg;

    typedef enum logic [1:0] {PARK, SETTLE, GRANT, DRAIN} arbState_t;

    localparam logic [1:0] SEL_SRC0 = 2'b00;
    localparam logic [1:0] SEL_SRC1 = 2'b01;
    localparam logic [1:0] SEL_SRC2 = 2'b10;
    localparam logic [1:0] SEL_PARK = 2'b11;

    function automatic logic [1:0] srcCode(input logic [1:0] idx);
        return idx == 2'd0 ? SEL_SRC0 : idx == 2'd1 ? SEL_SRC1 : idx == 2'd2 ? SEL_SRC2 : SEL_PARK;
    endfunction

endpackage

// File: rtl/op_arb_cycle_counter.sv
// op_arb_cycle_counter: loadable up/down counter; done flags terminal match when counting up, zero when counting down.
module op_arb_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] loadVal,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count;
    logic         isZero;
    logic         atTerminal;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (en)
            count <= up ? count + W'(1) : count - W'(1);

    assign isZero     = count == '0;
    assign atTerminal = count == terminal;
    assign done       = up ? atTerminal : isZero;

endmodule

// File: rtl/op_data_arbiter.sv
// op_data_arbiter: three-source operand-data bus arbiter with settle window and break-before-make park.
// Define OPSEL_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority src0 > src1 > src2.
module op_data_arbiter
    import op_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 2,
    parameter int MAX_HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] selectorBits,
    output logic       busy,
    output logic       holdTimeout
);

    localparam int CNT_MAX = (SETTLE_CYCLES > MAX_HOLD_CYCLES) ? SETTLE_CYCLES : MAX_HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    arbState_t  state, nextState;
    logic [2:0] nextGnt;
    logic [1:0] nextSel;
    logic       nextTimeout;
    logic [1:0] winner;
    logic [3:0] reqExt;
    logic       wReq;
    logic       settleLoad, settleDone;
    logic       holdLoad, holdDone;

    // While a source owns the bus, selectorBits holds its index, so it doubles as the winner register.
    assign reqExt = {1'b0, req};
    assign wReq   = reqExt[selectorBits];

`ifdef OPSEL_ROUND_ROBIN_EN
    logic [1:0] rrPtr;
    logic [1:0] idx;

    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = 2'((int'(rrPtr) + k) % 3);
            if (req[idx]) winner = idx;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            rrPtr <= 2'd0;
        else if (holdLoad)
            rrPtr <= selectorBits == SEL_SRC2 ? 2'd0 : selectorBits + 2'd1;
`else
    assign winner = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`endif

    op_arb_cycle_counter #(.W(CW)) settleCnt (
        .clk      (clk),
        .reset    (reset),
        .load     (settleLoad),
        .en       (state == SETTLE && !settleDone),
        .up       (1'b0),
        .loadVal  (CW'(SETTLE_CYCLES - 1)),
        .terminal ('0),
        .done     (settleDone)
    );

    op_arb_cycle_counter #(.W(CW)) holdCnt (
        .clk      (clk),
        .reset    (reset),
        .load     (holdLoad),
        .en       (state == GRANT && MAX_HOLD_CYCLES != 0 && !holdDone),
        .up       (1'b1),
        .loadVal  ('0),
        .terminal (CW'(MAX_HOLD_CYCLES == 0 ? 0 : MAX_HOLD_CYCLES - 1)),
        .done     (holdDone)
    );

    always_comb begin
        nextState   = state;
        nextGnt     = gnt;
        nextSel     = selectorBits;
        nextTimeout = 1'b0;
        settleLoad  = 1'b0;
        holdLoad    = 1'b0;
        case (state)
            PARK:
                if (|req) begin
                    nextState  = SETTLE;
                    nextSel    = srcCode(winner);
                    settleLoad = 1'b1;
                end
            SETTLE:
                if (!wReq) begin
                    nextState = DRAIN;
                    nextSel   = SEL_PARK;
                end else if (settleDone) begin
                    nextState = GRANT;
                    nextGnt   = 3'b001 << selectorBits;
                    holdLoad  = 1'b1;
                end
            GRANT:
                if (!wReq || (MAX_HOLD_CYCLES != 0 && holdDone)) begin
                    nextState   = DRAIN;
                    nextGnt     = 3'b000;
                    nextSel     = SEL_PARK;
                    nextTimeout = wReq;
                end
            default: begin
                nextState = PARK;
                nextGnt   = 3'b000;
                nextSel   = SEL_PARK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= PARK;
            gnt          <= 3'b000;
            selectorBits <= SEL_PARK;
            busy         <= 1'b0;
            holdTimeout  <= 1'b0;
        end else begin
            state        <= nextState;
            gnt          <= nextGnt;
            selectorBits <= nextSel;
            busy         <= nextState != PARK;
            holdTimeout  <= nextTimeout;
        end

endmodule
